// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants and the per-axis region encoding
// shared by the sync generator and its axis counters.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {
      VIS  = 2'd0,
      FP   = 2'd1,
      SYNC = 2'd2,
      BP   = 2'd3
   } region_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap-around position counter plus the region FSM
// (visible / front porch / sync / back porch) that follows it.
module vga_axis_counter
   import vga_timing_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic [CNT_W-1:0] fp_start,
   input  logic [CNT_W-1:0] sync_start,
   input  logic [CNT_W-1:0] bp_start,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] count,
   output region_t          region,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_nxt;
   region_t          region_nxt;

   // ">=" rather than "==" so an out-of-range count recovers on the next step.
   assign wrap = (count >= last);

   always_comb begin
      cnt_nxt    = count;
      region_nxt = region;
      if (step) begin
         cnt_nxt = wrap ? '0 : count + CNT_W'(1);
         case (region)
            VIS:  if (cnt_nxt == fp_start)   region_nxt = FP;
            FP:   if (cnt_nxt == sync_start) region_nxt = SYNC;
            SYNC: if (cnt_nxt == bp_start)   region_nxt = BP;
            default: region_nxt = region;
         endcase
         if (cnt_nxt == '0) region_nxt = VIS;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         region <= VIS;
      end else begin
         count  <= cnt_nxt;
         region <= region_nxt;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: registered hsync/vsync/video_on, pixel coordinates and
// line/frame strobes. Define VGA_FRAME_CNT_EN to build the 8-bit frame counter.
module vga_sync_gen #(
   parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int   H_BACK      = vga_timing_pkg::H_BACK,
   parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int   V_BACK      = vga_timing_pkg::V_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             pix_en,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             video_on,
   output logic [vga_timing_pkg::CNT_W-1:0] pixel_x,
   output logic [vga_timing_pkg::CNT_W-1:0] pixel_y,
   output logic                             line_start,
   output logic                             frame_start,
   output logic [7:0]                       frame_cnt
);

   import vga_timing_pkg::*;

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   logic [CNT_W-1:0] h_cnt, v_cnt;
   region_t          h_region, v_region;
   logic             h_wrap;
   logic             v_wrap_unused;

   vga_axis_counter u_h_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (pix_en),
      .fp_start   (CNT_W'(H_VISIBLE)),
      .sync_start (CNT_W'(H_VISIBLE + H_FRONT)),
      .bp_start   (CNT_W'(H_VISIBLE + H_FRONT + H_SYNC)),
      .last       (CNT_W'(H_TOT - 1)),
      .count      (h_cnt),
      .region     (h_region),
      .wrap       (h_wrap)
   );

   vga_axis_counter u_v_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (pix_en & h_wrap),
      .fp_start   (CNT_W'(V_VISIBLE)),
      .sync_start (CNT_W'(V_VISIBLE + V_FRONT)),
      .bp_start   (CNT_W'(V_VISIBLE + V_FRONT + V_SYNC)),
      .last       (CNT_W'(V_TOT - 1)),
      .count      (v_cnt),
      .region     (v_region),
      .wrap       (v_wrap_unused)
   );

   // Outputs register the counter/region pair of the same step, so coordinates,
   // syncs and strobes are mutually aligned one clk behind the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            hsync       <= (h_region == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= (v_region == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= (h_region == VIS) && (v_region == VIS);
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= 8'd0;
      end else if (pix_en && (h_cnt == '0) && (v_cnt == '0)) begin
         frame_q <= frame_q + 8'd1;
      end
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the 25 MHz pixel clock/tick from the frequency divider and generates 640x480@60 Hz VGA timing.
- Outputs: hsync, vsync, video_on, current pixel coordinates, and line/frame start strobes.
- Feeds the game's pixel renderer and the VGA output pins.
- Horizontal and vertical region state machines are driven by wrap-around counters.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel tick; tie to 1 when clk is already the 25 MHz clock
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while the pixel is inside the visible area
- pixel_x  output  10  current column, 0..799
- pixel_y  output  10  current row, 0..524
- line_start  output  1  one-cycle strobe when pixel_x becomes 0
- frame_start  output  1  one-cycle strobe when (pixel_x, pixel_y) becomes (0, 0)
- frame_cnt  output  8  frame counter (see Optional Feature)

Behaviour:
- Interface fixed: single clock clk; reset is asynchronous and active-high.
- Counters:
  - Internal h_cnt and v_cnt, both 10 bits.
  - H_TOTAL = 800 and V_TOTAL = 525, derived as the sum of the parameters.
- Advancing on pix_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only in the cycle h_cnt wraps; at V_TOTAL-1 it wraps to 0.
  - Simultaneous wrap of both counters (799, 524) -> (0, 0).
- Holding on pix_en=0: counters, all outputs and all states hold. Strobes are forced to 0.
- H region FSM states, advanced by h_cnt:
  - H_VIS: 0..639
  - H_FP: 640..655
  - H_SYNC: 656..751
  - H_BP: 752..799
- V region FSM states, using the same scheme with the V_* bounds:
  - V_VIS: 0..479
  - V_FP: 480..489
  - V_SYNC: 490..491
  - V_BP: 492..524
- FSM transitions happen only on a pix_en cycle, at the boundary counts listed above.
- Outputs:
  - All outputs are registered and mutually aligned, with no skew between coordinates and sync.
  - pixel_x/pixel_y equal h_cnt/v_cnt.
  - hsync = SYNC_ACTIVE in H_SYNC, otherwise ~SYNC_ACTIVE. vsync follows the same rule in V_SYNC.
  - video_on = (H_VIS && V_VIS).
- Strobe timing:
  - line_start is 1 for exactly one clk cycle, the first cycle in which pixel_x == 0 is presented.
  - frame_start is the same, additionally requiring pixel_y == 0.
- Reset values:
  - h_cnt = 0, v_cnt = 0, states H_VIS/V_VIS.
  - hsync = vsync = ~SYNC_ACTIVE, video_on = 0, pixel_x = pixel_y = 0.
  - line_start = frame_start = 0, frame_cnt = 0.
- First pix_en cycle after reset deassertion:
  - Outputs present (0, 0) with video_on=1, line_start=1, frame_start=1.
  - The counters then advance to (1, 0).
- Reset asserted mid-frame: immediate asynchronous return to the reset values. No partial sync pulse is held.
- Counter values outside the legal range (e.g. after an SEU) must wrap to 0 on the next pix_en.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- When defined:
  - frame_cnt increments by 1 (mod 256) in the same cycle frame_start is asserted.
  - The first frame after reset reads 1.
  - Used by the game for animation timing.
- When undefined: frame_cnt is constant 0 and no counter register is synthesised.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants, H_TOTAL and V_TOTAL;
  - the region state encodings VIS/FP/SYNC/BP (2 bits);
  - the counter width of 10.
- Sub-module vga_axis_counter:
  - One instance per axis.
  - Contains the counter, wrap logic and region FSM.
  - Inputs are the step enable and the four bounds.
  - Outputs are the count, the region and a wrap flag.
  - The H instance's wrap flag ANDed with pix_en drives the V instance's step.

Test Plan:
- Reset release, pix_en=1 constant → first cycle (0,0), video_on=1, frame_start=1, line_start=1; hsync=vsync=1.
- Count 656 cycles after frame start → hsync falls at pixel_x=656, rises at 752; video_on=0 from pixel_x=640.
- Run one full line (800 cycles) → pixel_x wraps 799→0, pixel_y 0→1, line_start pulses once, frame_start stays 0.
- Run a full frame (420000 cycles):
  - vsync is low exactly for lines 490–491 (1600 cycles).
  - frame_start recurs at cycle 420000.
  - With VGA_FRAME_CNT_EN, frame_cnt reads 2.
- pix_en toggled 1,0,1,0 → coordinates advance every other clk; strobes never high on pix_en=0 cycles; outputs hold value.
- Assert reset at (700, 491) mid-vsync → outputs immediately at reset values; after release, restart at (0,0).
